axi_mm_a32_d128_master_slice: RTL and testbench

Master-side logic-link adapter for the AXI-MM A32/D128 link, at the opposite end of the link from the slave-side adapter. It accepts AR/AW/W from a local AXI master and packs them into txfifo words. It unpacks R/B rxfifo words back onto the master's AXI response ports. Every channel is cut by a two-entry skid buffer, so all valid, ready and data outputs are registered, and optional outstanding-transaction limiting throttles AR/AW.

---
 rtl/axi_mm_a32_d128_master_slice.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_mm_a32_d128_master_slice.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_a32_d128_master_slice.sv
// Master-side AXI-MM A32/D128 link adapter: packs AR/AW/W into txfifo words and unpacks R/B.
// Optional outstanding-burst throttling is enabled by AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN.

module axi_mm_a32_d128_master_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  input  logic         block_i
);

  // Bit 0 of the encoding doubles as the main-register valid flag.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           ready_q, ready_d;
  logic           accept;
  logic           take;

  assign accept      = in_valid_i & ready_q;
  assign take        = state_q[0] & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = state_q[0];
  assign out_data_o  = main_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({accept, take})
          2'b01: state_d = EMPTY;
          2'b10: begin
            skid_d  = in_data_i;
            state_d = FULL;
          end
          2'b11: main_d = in_data_i;
          default: ;
        endcase
      end
      FULL: begin
        if (take) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is decided from the next state so it can be registered.
    ready_d = (state_d != FULL) & ~block_i;
  end

endmodule

module axi_mm_a32_d128_master_slice #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic         clk_wr,
  input  logic         rst_wr_n,
  input  logic [3:0]   user_arid,
  input  logic [2:0]   user_arsize,
  input  logic [7:0]   user_arlen,
  input  logic [1:0]   user_arburst,
  input  logic [31:0]  user_araddr,
  input  logic         user_arvalid,
  output logic         user_arready,
  input  logic [3:0]   user_awid,
  input  logic [2:0]   user_awsize,
  input  logic [7:0]   user_awlen,
  input  logic [1:0]   user_awburst,
  input  logic [31:0]  user_awaddr,
  input  logic         user_awvalid,
  output logic         user_awready,
  input  logic [3:0]   user_wid,
  input  logic [127:0] user_wdata,
  input  logic [15:0]  user_wstrb,
  input  logic         user_wlast,
  input  logic         user_wvalid,
  output logic         user_wready,
  output logic [3:0]   user_rid,
  output logic [127:0] user_rdata,
  output logic         user_rlast,
  output logic [1:0]   user_rresp,
  output logic         user_rvalid,
  input  logic         user_rready,
  output logic [3:0]   user_bid,
  output logic [1:0]   user_bresp,
  output logic         user_bvalid,
  input  logic         user_bready,
  output logic         user_ar_valid,
  output logic [48:0]  txfifo_ar_data,
  input  logic         user_ar_ready,
  output logic         user_aw_valid,
  output logic [48:0]  txfifo_aw_data,
  input  logic         user_aw_ready,
  output logic         user_w_valid,
  output logic [148:0] txfifo_w_data,
  input  logic         user_w_ready,
  input  logic         user_r_valid,
  input  logic [134:0] rxfifo_r_data,
  output logic         user_r_ready,
  input  logic         user_b_valid,
  input  logic [5:0]   rxfifo_b_data,
  output logic         user_b_ready,
  input  logic         m_gen2_mode,
  output logic [7:0]   rd_outstanding,
  output logic [7:0]   wr_outstanding
);

  logic         ar_block;
  logic         aw_block;
  logic [134:0] r_word;
  logic [5:0]   b_word;

  wire unused_gen2 = m_gen2_mode;

  axi_mm_a32_d128_master_slice_skid #(.W(49)) u_ar (
    .clk_i(clk_wr), .rst_n_i(rst_wr_n),
    .in_valid_i(user_arvalid),
    .in_data_i({user_araddr, user_arburst, user_arlen, user_arsize, user_arid}),
    .in_ready_o(user_arready),
    .out_valid_o(user_ar_valid), .out_data_o(txfifo_ar_data),
    .out_ready_i(user_ar_ready), .block_i(ar_block)
  );

  axi_mm_a32_d128_master_slice_skid #(.W(49)) u_aw (
    .clk_i(clk_wr), .rst_n_i(rst_wr_n),
    .in_valid_i(user_awvalid),
    .in_data_i({user_awaddr, user_awburst, user_awlen, user_awsize, user_awid}),
    .in_ready_o(user_awready),
    .out_valid_o(user_aw_valid), .out_data_o(txfifo_aw_data),
    .out_ready_i(user_aw_ready), .block_i(aw_block)
  );

  axi_mm_a32_d128_master_slice_skid #(.W(149)) u_w (
    .clk_i(clk_wr), .rst_n_i(rst_wr_n),
    .in_valid_i(user_wvalid),
    .in_data_i({user_wlast, user_wstrb, user_wdata, user_wid}),
    .in_ready_o(user_wready),
    .out_valid_o(user_w_valid), .out_data_o(txfifo_w_data),
    .out_ready_i(user_w_ready), .block_i(1'b0)
  );

  axi_mm_a32_d128_master_slice_skid #(.W(135)) u_r (
    .clk_i(clk_wr), .rst_n_i(rst_wr_n),
    .in_valid_i(user_r_valid), .in_data_i(rxfifo_r_data),
    .in_ready_o(user_r_ready),
    .out_valid_o(user_rvalid), .out_data_o(r_word),
    .out_ready_i(user_rready), .block_i(1'b0)
  );

  axi_mm_a32_d128_master_slice_skid #(.W(6)) u_b (
    .clk_i(clk_wr), .rst_n_i(rst_wr_n),
    .in_valid_i(user_b_valid), .in_data_i(rxfifo_b_data),
    .in_ready_o(user_b_ready),
    .out_valid_o(user_bvalid), .out_data_o(b_word),
    .out_ready_i(user_bready), .block_i(1'b0)
  );

  assign user_rid   = r_word[3:0];
  assign user_rdata = r_word[131:4];
  assign user_rlast = r_word[132];
  assign user_rresp = r_word[134:133];
  assign user_bid   = b_word[3:0];
  assign user_bresp = b_word[5:4];

`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
  localparam logic [7:0] MaxCnt = 8'(MAX_OUTSTANDING);

  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic       rd_inc, rd_dec, wr_inc, wr_dec;

  assign rd_inc = user_arvalid & user_arready;
  assign rd_dec = user_rvalid & user_rready & user_rlast;
  assign wr_inc = user_awvalid & user_awready;
  assign wr_dec = user_bvalid & user_bready;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_inc && !rd_dec) rd_cnt_d = rd_cnt_q + 8'd1;
    else if (rd_dec && !rd_inc) rd_cnt_d = rd_cnt_q - 8'd1;
    if (wr_inc && !wr_dec) wr_cnt_d = wr_cnt_q + 8'd1;
    else if (wr_dec && !wr_inc) wr_cnt_d = wr_cnt_q - 8'd1;
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // A response with no burst in flight means the far end is misbehaving.
  always_ff @(posedge clk_wr) begin
    if (rst_wr_n && rd_dec && !rd_inc) assert (rd_cnt_q != 8'd0);
    if (rst_wr_n && wr_dec && !wr_inc) assert (wr_cnt_q != 8'd0);
  end

  assign ar_block       = (rd_cnt_d == MaxCnt);
  assign aw_block       = (wr_cnt_d == MaxCnt);
  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
`else
  wire unused_cfg = ^{8'(MAX_OUTSTANDING)};

  assign ar_block       = 1'b0;
  assign aw_block       = 1'b0;
  assign rd_outstanding = '0;
  assign wr_outstanding = '0;
`endif

endmodule

// File: tb/tb_axi_mm_a32_d128_master_slice.sv
// Bench for axi_mm_a32_d128_master_slice: per-channel FIFO reference model, vector table,
// hand-written corner sequences and a randomized phase.

module tb_axi_mm_a32_d128_master_slice;

  localparam int MaxOut = 2;

  logic clk_wr = 1'b0;
  logic rst_wr_n = 1'b0;
  always #5 clk_wr = ~clk_wr;

  // Channel index: 0 AR, 1 AW, 2 W, 3 R, 4 B
  logic         inValid [5];
  logic [148:0] inData  [5];
  logic         outReady[5];

  logic         user_arready, user_awready, user_wready;
  logic [3:0]   user_rid, user_bid;
  logic [127:0] user_rdata;
  logic         user_rlast, user_rvalid, user_bvalid;
  logic [1:0]   user_rresp, user_bresp;
  logic         user_ar_valid, user_aw_valid, user_w_valid;
  logic [48:0]  txfifo_ar_data, txfifo_aw_data;
  logic [148:0] txfifo_w_data;
  logic         user_r_ready, user_b_ready;
  logic [7:0]   rd_outstanding, wr_outstanding;

  axi_mm_a32_d128_master_slice #(.MAX_OUTSTANDING(MaxOut)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .user_arid(inData[0][3:0]), .user_arsize(inData[0][6:4]), .user_arlen(inData[0][14:7]),
    .user_arburst(inData[0][16:15]), .user_araddr(inData[0][48:17]),
    .user_arvalid(inValid[0]), .user_arready(user_arready),
    .user_awid(inData[1][3:0]), .user_awsize(inData[1][6:4]), .user_awlen(inData[1][14:7]),
    .user_awburst(inData[1][16:15]), .user_awaddr(inData[1][48:17]),
    .user_awvalid(inValid[1]), .user_awready(user_awready),
    .user_wid(inData[2][3:0]), .user_wdata(inData[2][131:4]), .user_wstrb(inData[2][147:132]),
    .user_wlast(inData[2][148]), .user_wvalid(inValid[2]), .user_wready(user_wready),
    .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast), .user_rresp(user_rresp),
    .user_rvalid(user_rvalid), .user_rready(outReady[3]),
    .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid), .user_bready(outReady[4]),
    .user_ar_valid(user_ar_valid), .txfifo_ar_data(txfifo_ar_data), .user_ar_ready(outReady[0]),
    .user_aw_valid(user_aw_valid), .txfifo_aw_data(txfifo_aw_data), .user_aw_ready(outReady[1]),
    .user_w_valid(user_w_valid), .txfifo_w_data(txfifo_w_data), .user_w_ready(outReady[2]),
    .user_r_valid(inValid[3]), .rxfifo_r_data(inData[3][134:0]), .user_r_ready(user_r_ready),
    .user_b_valid(inValid[4]), .rxfifo_b_data(inData[4][5:0]), .user_b_ready(user_b_ready),
    .m_gen2_mode(1'b0),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: each channel is a FIFO that holds at most two beats.
  logic [148:0] mem [5][4];
  int           head[5];
  int           cnt [5];
  logic         resetSeen = 1'b1;
  int           rdCnt = 0;
  int           wrCnt = 0;
  int           wPops = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [48:0] expWord;
  } axVec_t;

  axVec_t vecs[5];

  function automatic logic [148:0] chanMask(int c);
    case (c)
      0, 1:    return 149'({49{1'b1}});
      2:       return {149{1'b1}};
      3:       return 149'({135{1'b1}});
      default: return 149'(6'h3F);
    endcase
  endfunction

  function automatic logic dutOutValid(int c);
    case (c)
      0:       return user_ar_valid;
      1:       return user_aw_valid;
      2:       return user_w_valid;
      3:       return user_rvalid;
      default: return user_bvalid;
    endcase
  endfunction

  function automatic logic dutInReady(int c);
    case (c)
      0:       return user_arready;
      1:       return user_awready;
      2:       return user_wready;
      3:       return user_r_ready;
      default: return user_b_ready;
    endcase
  endfunction

  function automatic logic [148:0] dutOutData(int c);
    case (c)
      0:       return 149'(txfifo_ar_data);
      1:       return 149'(txfifo_aw_data);
      2:       return txfifo_w_data;
      3:       return 149'({user_rresp, user_rlast, user_rdata, user_rid});
      default: return 149'({user_bresp, user_bid});
    endcase
  endfunction

  function automatic logic expReady(int c);
    logic r;
    r = !resetSeen && (cnt[c] < 2);
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
    if (c == 0 && rdCnt == MaxOut) r = 1'b0;
    if (c == 1 && wrCnt == MaxOut) r = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [148:0] rand149();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[148:0];
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: checks outputs against the
  // model, advances the model by the coming rising edge, then waits for the next falling edge.
  task automatic applyStimulus();
    logic acc [5];
    logic fire[5];
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
    logic rLastOut;
`endif
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("ch%0d_valid", c), 160'(dutOutValid(c)), 160'(!resetSeen && cnt[c] > 0));
      checkOutput($sformatf("ch%0d_ready", c), 160'(dutInReady(c)), 160'(expReady(c)));
      if (resetSeen)
        checkOutput($sformatf("ch%0d_reset_data", c), 160'(dutOutData(c)), 160'(0));
      else if (cnt[c] > 0)
        checkOutput($sformatf("ch%0d_data", c), 160'(dutOutData(c)), 160'(mem[c][head[c]]));
    end
    checkOutput("rd_outstanding", 160'(rd_outstanding), 160'(rdCnt));
    checkOutput("wr_outstanding", 160'(wr_outstanding), 160'(wrCnt));
    if (!rst_wr_n) begin
      for (int c = 0; c < 5; c++) begin
        cnt[c]  = 0;
        head[c] = 0;
      end
      rdCnt = 0;
      wrCnt = 0;
      resetSeen = 1'b1;
    end else begin
      for (int c = 0; c < 5; c++) begin
        acc[c]  = inValid[c] && expReady(c);
        fire[c] = !resetSeen && cnt[c] > 0 && outReady[c];
      end
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
      rLastOut = mem[3][head[3]][132];
      if (acc[0]) rdCnt++;
      if (fire[3] && rLastOut) rdCnt--;
      if (acc[1]) wrCnt++;
      if (fire[4]) wrCnt--;
`endif
      for (int c = 0; c < 5; c++) begin
        if (fire[c]) begin
          head[c] = (head[c] + 1) % 4;
          cnt[c]--;
          if (c == 2) wPops++;
        end
        if (acc[c]) begin
          if (cnt[c] < 4) mem[c][(head[c] + cnt[c]) % 4] = inData[c] & chanMask(c);
          cnt[c]++;
        end
      end
      resetSeen = 1'b0;
    end
    @(negedge clk_wr);
  endtask

  task automatic pulseReset();
    rst_wr_n = 1'b0;
    applyStimulus();
    rst_wr_n = 1'b1;
    applyStimulus();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int wStart;
    logic sawLow;
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
    int pend;
`endif
    vecs[0] = '{4'hA, 3'h4, 8'h0F, 2'h1, 32'hDEADBEEF, 49'h1BD5B7DDE87CA};
    vecs[1] = '{4'h0, 3'h0, 8'h00, 2'h0, 32'h00000000, 49'h0};
    vecs[2] = '{4'hF, 3'h7, 8'hFF, 2'h3, 32'hFFFFFFFF, 49'h1FFFFFFFFFFFF};
    vecs[3] = '{4'h1, 3'h0, 8'h00, 2'h0, 32'h00000001, 49'h0000000020001};
    vecs[4] = '{4'h0, 3'h2, 8'h80, 2'h2, 32'h80000000, 49'h1000000014020};

    for (int c = 0; c < 5; c++) begin
      inValid[c] = 1'b0;
      inData[c]  = '0;
      outReady[c] = 1'b1;
      head[c] = 0;
      cnt[c]  = 0;
    end

    $display("[TB] reset and release");
    @(negedge clk_wr);
    applyStimulus();
    rst_wr_n = 1'b1;
    applyStimulus();
    checkOutput("arready_after_release", 160'(user_arready), 160'(1));
    checkOutput("wready_after_release", 160'(user_wready), 160'(1));

    $display("[TB] AR/AW packing table");
    for (int v = 0; v < 5; v++) begin
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
      pulseReset();
`endif
      inData[0] = 149'({vecs[v].addr, vecs[v].burst, vecs[v].len, vecs[v].size, vecs[v].id});
      inData[1] = inData[0];
      inValid[0] = 1'b1;
      inValid[1] = 1'b1;
      applyStimulus();
      inValid[0] = 1'b0;
      inValid[1] = 1'b0;
      checkOutput($sformatf("ar_valid_vec%0d", v), 160'(user_ar_valid), 160'(1));
      checkOutput($sformatf("ar_word_vec%0d", v), 160'(txfifo_ar_data), 160'(vecs[v].expWord));
      checkOutput($sformatf("aw_word_vec%0d", v), 160'(txfifo_aw_data), 160'(vecs[v].expWord));
      applyStimulus();
      checkOutput($sformatf("ar_valid_one_cycle_vec%0d", v), 160'(user_ar_valid), 160'(0));
    end

    $display("[TB] W backpressure");
    idx = 0;
    wStart = wPops;
    sawLow = 1'b0;
    for (int k = 0; k < 40 && (idx < 8 || cnt[2] > 0); k++) begin
      outReady[2] = !(k >= 2 && k < 7);
      inValid[2] = (idx < 8);
      inData[2]  = {(idx == 7), 16'hFFFF, 128'(idx), 4'h0};
      if (!dutInReady(2)) sawLow = 1'b1;
      if (inValid[2] && expReady(2)) idx++;
      applyStimulus();
    end
    inValid[2] = 1'b0;
    outReady[2] = 1'b1;
    checkOutput("w_beats_out", 160'(wPops - wStart), 160'(8));
    checkOutput("w_ready_fell", 160'(sawLow), 160'(1));

    $display("[TB] R unpack");
    inData[3] = 149'({2'd2, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 4'd3});
    inValid[3] = 1'b1;
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
    inData[0] = '0;
    inValid[0] = 1'b1;
`endif
    applyStimulus();
    inValid[3] = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("r_id", 160'(user_rid), 160'(3));
    checkOutput("r_resp", 160'(user_rresp), 160'(2));
    checkOutput("r_last", 160'(user_rlast), 160'(1));
    checkOutput("r_data", 160'(user_rdata), 160'(128'h0123456789ABCDEF0123456789ABCDEF));
    applyStimulus();

    $display("[TB] reset mid-burst");
    outReady[0] = 1'b0;
    outReady[2] = 1'b0;
    inValid[0] = 1'b1;
    inValid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inData[0] = rand149() & chanMask(0);
      inData[2] = rand149();
      applyStimulus();
    end
    checkOutput("ar_not_ready_before_reset", 160'(user_arready), 160'(0));
    checkOutput("w_not_ready_before_reset", 160'(user_wready), 160'(0));
    inValid[0] = 1'b0;
    inValid[2] = 1'b0;
    rst_wr_n = 1'b0;
    applyStimulus();
    checkOutput("ar_valid_in_reset", 160'(user_ar_valid), 160'(0));
    checkOutput("w_ready_in_reset", 160'(user_wready), 160'(0));
    checkOutput("w_data_in_reset", 160'(txfifo_w_data), 160'(0));
    rst_wr_n = 1'b1;
    outReady[0] = 1'b1;
    outReady[2] = 1'b1;
    applyStimulus();
    checkOutput("ar_ready_after_reset", 160'(user_arready), 160'(1));
    checkOutput("w_ready_after_reset", 160'(user_wready), 160'(1));
    applyStimulus();
    checkOutput("w_no_stale_beat", 160'(user_w_valid), 160'(0));

`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
    $display("[TB] outstanding limit");
    inValid[0] = 1'b1;
    inData[0] = 149'(49'h1234);
    for (int k = 0; k < 4; k++) applyStimulus();
    checkOutput("rd_limit_count", 160'(rd_outstanding), 160'(MaxOut));
    checkOutput("rd_limit_ready", 160'(user_arready), 160'(0));
    inData[3] = 149'({2'd0, 1'b1, 128'h5, 4'd1});
    inValid[3] = 1'b1;
    applyStimulus();
    inValid[3] = 1'b0;
    applyStimulus();
    checkOutput("rd_ready_restored", 160'(user_arready), 160'(1));
    applyStimulus();
    inValid[0] = 1'b0;
    checkOutput("rd_third_accepted", 160'(rd_outstanding), 160'(MaxOut));
    applyStimulus();

    $display("[TB] simultaneous AW accept and B handshake");
    pulseReset();
    inValid[1] = 1'b1;
    applyStimulus();
    inValid[1] = 1'b0;
    outReady[4] = 1'b0;
    inValid[4] = 1'b1;
    inData[4] = 149'(6'h21);
    applyStimulus();
    inValid[4] = 1'b0;
    applyStimulus();
    inValid[1] = 1'b1;
    outReady[4] = 1'b1;
    applyStimulus();
    inValid[1] = 1'b0;
    checkOutput("wr_simultaneous", 160'(wr_outstanding), 160'(1));
    applyStimulus();
`endif

    $display("[TB] randomized traffic");
    for (int k = 0; k < 2500; k++) begin
      rst_wr_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < 5; c++) begin
        outReady[c] = ($urandom_range(0, 3) != 0);
        inValid[c]  = ($urandom_range(0, 2) != 0);
        inData[c]   = rand149() & chanMask(c);
      end
`ifdef AXI_MM_A32_D128_MASTER_SLICE_OUTSTANDING_EN
      pend = 0;
      for (int e = 0; e < cnt[3]; e++) if (mem[3][(head[3] + e) % 4][132]) pend++;
      if (rdCnt - pend <= 0) inData[3][132] = 1'b0;
      if (wrCnt - cnt[4] <= 0) inValid[4] = 1'b0;
`endif
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
